wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage pipeline, directly downstream of the memory stage. Captures the memory stage's register-write collect bus, PC and 7-bit exception bus into one pipeline register. Retires the instruction: drives the register-file write port, the forwarding bus and the debug trace. Detects exceptions and `ertn` at commit and raises the pipeline-wide `except_flush` with the redirect PC.

## Interface

Parameters: none.

Ports:
- `clk` in 1: pipeline clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `ws_allowin` out 1: WB can accept an instruction this cycle.
- `ms_to_ws_valid` in 1: memory stage presents a valid instruction.
- `ms_rf_collect` in 38: `{we, waddr[4:0], wdata[31:0]}`. `we` is already qualified by the memory-stage valid.
- `ms_pc` in 32: PC of the presented instruction.
- `ms_to_ws_bus` in 7: exception flags `{sys, brk, ine, ale, adef, int, ertn}`, bit 6 down to bit 0.
- `csr_eentry` in 32: exception entry address.
- `csr_era` in 32: return address used by `ertn`.
- `ws_rf_collect` out 38: `{rf_we, rf_waddr, rf_wdata}` forwarding bus to decode.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32: register-file write port.
- `debug_wb_pc` out 32, `debug_wb_rf_we` out 4, `debug_wb_rf_wnum` out 5, `debug_wb_rf_wdata` out 32: commit trace.
- `except_flush` out 1: flush all younger stages.
- `flush_pc` out 32: redirect target, valid while `except_flush`=1.
- `ws_ex` out 1, `ws_ecode` out 6, `ws_era` out 32: exception commit record to the CSR block.
- `ws_ertn` out 1: `ertn` commit to the CSR block.
- `ws_retire_cnt` out 32: retired-instruction count (see Configuration).

## Operation

- Stage register contents:
  - `ws_valid`, `ws_pc`, `ws_we`, `ws_waddr`, `ws_wdata`, `ws_exc[6:0]`.
  - Loaded when `ms_to_ws_valid & ws_allowin` and `except_flush`=0.
- Handshake:
  - `ws_ready_go`=1.
  - `ws_allowin = ~ws_valid | ws_ready_go` (no downstream).
  - `ws_valid` next value is `ms_to_ws_valid & ws_allowin & ~except_flush`.
- Exception decode:
  - Any of `sys, brk, ine, ale, adef, int` set in a valid instruction gives `ws_ex`=1.
  - `ws_ertn = ws_valid & exc[0] & ~ws_ex`.
- `ws_ecode` priority, highest first:
  - int: 0x00
  - adef: 0x08
  - ine: 0x0D
  - sys: 0x0B
  - brk: 0x0C
  - ale: 0x09
  - It is 0 when `ws_ex`=0.
- Flush outputs:
  - `ws_era = ws_pc`.
  - `except_flush = ws_ex | ws_ertn`.
  - `flush_pc = ws_ex ? csr_eentry : csr_era`. When neither is set, `flush_pc` is 0.
- Write suppression:
  - `rf_we = ws_valid & ws_we & ~ws_ex`. An excepting instruction never writes the register file.
  - `ertn` carries `we`=0 from decode. It is not forced.
- Forwarding bus: `ws_rf_collect = {rf_we, ws_waddr, ws_wdata}`.
- Register-file port: `rf_waddr = ws_waddr`, `rf_wdata = ws_wdata`.
- Trace:
  - `debug_wb_pc = ws_pc`.
  - `debug_wb_rf_we = {4{rf_we}}`.
  - `debug_wb_rf_wnum = ws_waddr`.
  - `debug_wb_rf_wdata = ws_wdata`.
- Register 0:
  - Writes to r0 pass through unchanged.
  - The register file discards them.

## Timing

- Reset:
  - Asynchronous assert clears every stage register to 0.
  - All outputs are then 0, except `ws_allowin`=1.
  - First capture happens on the first rising edge after `resetn` deasserts.
- Latency: one cycle. An instruction accepted at edge N drives the write port and trace during cycle N..N+1 and is written at edge N+1.
- `except_flush`:
  - Combinational from the stage register.
  - High for exactly the one cycle the excepting or `ertn` instruction sits in WB.
- Edge that ends a flush cycle:
  - `ws_valid` becomes 0.
  - The instruction the memory stage offered in that cycle is discarded, not captured.
  - Upstream stages clear their valids on the same edge.
- Back-to-back:
  - No bubbles; one retire per cycle.
  - `ws_allowin` stays 1 while running.
- Async reset during a flush cycle: flush drops immediately and nothing is captured.
- Bubble: `ms_to_ws_valid`=0 gives `ws_valid`=0 next cycle. All write/trace enables and flush are then 0; data fields hold their last values.

## Configuration

- Macro `WB_RETIRE_CNT_EN`, defined:
  - 32-bit counter, reset 0.
  - Increments on every edge where `ws_valid & ~ws_ex` (`ertn` counts).
  - Wraps 0xFFFFFFFF to 0.
  - Drives `ws_retire_cnt`.
- Not defined: no counter register; `ws_retire_cnt` is tied to 0.

## Test plan

- Reset release, then `ms_to_ws_valid`=1, collect `{1,5'd3,32'h1234_5678}`, pc 0x1C00_0000:
  - Next cycle `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0x12345678, `debug_wb_pc`=0x1C000000, `debug_wb_rf_we`=4'hF.
- Four back-to-back valid instructions: four consecutive retire cycles with no bubble; `ws_retire_cnt`=4 with `WB_RETIRE_CNT_EN`.
- Instruction with bus 7'b1000000 (sys), `we`=1, `csr_eentry`=0x1C00_8000, pc 0x1C00_0010:
  - `rf_we`=0, `except_flush`=1 for one cycle, `ws_ecode`=0x0B, `ws_era`=0x1C000010, `flush_pc`=0x1C008000.
  - Following instruction offered in the same cycle is not retired.
- Bus 7'b0000011 (int+ertn):
  - `ws_ex`=1, `ws_ecode`=0x00, `ws_ertn`=0.
- Bus 7'b0000001, `csr_era`=0x1C00_0044:
  - `ws_ertn`=1, `flush_pc`=0x1C000044, `rf_we`=0.
- Assert `resetn` low mid-stream while an excepting instruction sits in WB: outputs go to 0 immediately, no register write, counter returns to 0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: retires the instruction held in WB, drives the register-file port,
// forwarding bus and commit trace, and raises except_flush on exception/ertn commit.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage (
    input  logic        clk,
    input  logic        resetn,
    output logic        ws_allowin,
    input  logic        ms_to_ws_valid,
    input  logic [37:0] ms_rf_collect,
    input  logic [31:0] ms_pc,
    input  logic [6:0]  ms_to_ws_bus,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic [37:0] ws_rf_collect,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic        except_flush,
    output logic [31:0] flush_pc,
    output logic        ws_ex,
    output logic [5:0]  ws_ecode,
    output logic [31:0] ws_era,
    output logic        ws_ertn,
    output logic [31:0] ws_retire_cnt
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned EXW  = 7;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // Exception flag positions in the exception bus
    localparam int unsigned EX_ERTN = 0;
    localparam int unsigned EX_INT  = 1;
    localparam int unsigned EX_ADEF = 2;
    localparam int unsigned EX_ALE  = 3;
    localparam int unsigned EX_INE  = 4;
    localparam int unsigned EX_BRK  = 5;
    localparam int unsigned EX_SYS  = 6;

    logic            ws_valid;
    logic [XLEN-1:0] ws_pc;
    logic            ws_we;
    logic [AW-1:0]   ws_waddr;
    logic [XLEN-1:0] ws_wdata;
    logic [EXW-1:0]  ws_exc;
    logic            ws_ready_go;
    logic            load;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = ~ws_valid | ws_ready_go;
    // The instruction offered during a flush cycle is dropped, not captured
    assign load        = ms_to_ws_valid & ws_allowin & ~except_flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            ws_pc    <= '0;
            ws_we    <= 1'b0;
            ws_waddr <= '0;
            ws_wdata <= '0;
            ws_exc   <= '0;
        end else begin
            ws_valid <= load;
            if (load) begin
                ws_pc    <= ms_pc;
                ws_we    <= ms_rf_collect[37];
                ws_waddr <= ms_rf_collect[36:32];
                ws_wdata <= ms_rf_collect[31:0];
                ws_exc   <= ms_to_ws_bus;
            end
        end
    end

    assign ws_ex   = ws_valid & (|ws_exc[EXW-1:1]);
    assign ws_ertn = ws_valid & ws_exc[EX_ERTN] & ~ws_ex;

    // Exception code by commit priority
    always_comb begin
        ws_ecode = '0;
        if (ws_ex) begin
            if (ws_exc[EX_INT])       ws_ecode = ECODE_INT;
            else if (ws_exc[EX_ADEF]) ws_ecode = ECODE_ADEF;
            else if (ws_exc[EX_INE])  ws_ecode = ECODE_INE;
            else if (ws_exc[EX_SYS])  ws_ecode = ECODE_SYS;
            else if (ws_exc[EX_BRK])  ws_ecode = ECODE_BRK;
            else if (ws_exc[EX_ALE])  ws_ecode = ECODE_ALE;
            else                      ws_ecode = '0;
        end
    end

    always_comb begin
        flush_pc = '0;
        if (ws_ex)        flush_pc = csr_eentry;
        else if (ws_ertn) flush_pc = csr_era;
    end

    assign ws_era       = ws_pc;
    assign except_flush = ws_ex | ws_ertn;

    assign rf_we         = ws_valid & ws_we & ~ws_ex;
    assign rf_waddr      = ws_waddr;
    assign rf_wdata      = ws_wdata;
    assign ws_rf_collect = {rf_we, ws_waddr, ws_wdata};

    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_waddr;
    assign debug_wb_rf_wdata = ws_wdata;

`ifdef WB_RETIRE_CNT_EN
    logic [XLEN-1:0] retire_cnt;

    // ertn retires normally and is counted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                retire_cnt <= '0;
        else if (ws_valid & ~ws_ex) retire_cnt <= retire_cnt + XLEN'(1);
    end

    assign ws_retire_cnt = retire_cnt;
`else
    assign ws_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver pushes hand-computed commit records, a
// negedge monitor pops and compares whenever an instruction sits in WB.
module tb_wb_stage;

    logic        clk;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [37:0] ms_rf_collect;
    logic [31:0] ms_pc;
    logic [6:0]  ms_to_ws_bus;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic [37:0] ws_rf_collect;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        except_flush;
    logic [31:0] flush_pc;
    logic        ws_ex;
    logic [5:0]  ws_ecode;
    logic [31:0] ws_era;
    logic        ws_ertn;
    logic [31:0] ws_retire_cnt;

    wb_stage dut (
        .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_rf_collect(ms_rf_collect),
        .ms_pc(ms_pc), .ms_to_ws_bus(ms_to_ws_bus),
        .csr_eentry(csr_eentry), .csr_era(csr_era),
        .ws_rf_collect(ws_rf_collect), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata), .except_flush(except_flush),
        .flush_pc(flush_pc), .ws_ex(ws_ex), .ws_ecode(ws_ecode),
        .ws_era(ws_era), .ws_ertn(ws_ertn), .ws_retire_cnt(ws_retire_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ex;
        logic [5:0]  ecode;
        logic        ertn;
        logic        flush;
        logic [31:0] fpc;
    } exp_t;

    localparam logic [31:0] EENTRY = 32'h1C00_8000;
    localparam logic [31:0] ERA    = 32'h1C00_0044;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Offer one instruction for a cycle; push its record only if it is expected to retire
    task automatic send(input logic v, input logic [37:0] col, input logic [31:0] pc,
                        input logic [6:0] bus, input logic retire, input exp_t e);
        ms_to_ws_valid = v;
        ms_rf_collect  = col;
        ms_pc          = pc;
        ms_to_ws_bus   = bus;
        if (retire) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic ex, input logic [5:0] ec,
                                input logic ertn, input logic fl, input logic [31:0] fpc);
        exp_t e;
        e.pc = pc; e.we = we; e.waddr = wa; e.wdata = wd; e.ex = ex;
        e.ecode = ec; e.ertn = ertn; e.flush = fl; e.fpc = fpc;
        return e;
    endfunction

    // Monitor: compare the instruction in WB against the oldest expected record
    always @(negedge clk) begin
        if (resetn) begin
            chk("allowin", 32'(ws_allowin), 32'd1);
            if (dut.ws_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: pc %h with empty scoreboard", debug_wb_pc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("debug_wb_pc", debug_wb_pc, e.pc);
                    chk("rf_we", 32'(rf_we), 32'(e.we));
                    chk("debug_wb_rf_we", 32'(debug_wb_rf_we), e.we ? 32'hF : 32'h0);
                    chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                    chk("rf_wdata", rf_wdata, e.wdata);
                    chk("ws_rf_collect_hi", 32'(ws_rf_collect[37:32]), 32'({e.we, e.waddr}));
                    chk("debug_wdata", debug_wb_rf_wdata, e.wdata);
                    chk("ws_ex", 32'(ws_ex), 32'(e.ex));
                    chk("ws_ecode", 32'(ws_ecode), 32'(e.ecode));
                    chk("ws_ertn", 32'(ws_ertn), 32'(e.ertn));
                    chk("except_flush", 32'(except_flush), 32'(e.flush));
                    chk("flush_pc", flush_pc, e.fpc);
                    chk("ws_era", ws_era, e.pc);
`ifdef WB_RETIRE_CNT_EN
                    chk("retire_cnt", ws_retire_cnt, exp_cnt);
                    if (!e.ex) exp_cnt = exp_cnt + 32'd1;
`else
                    chk("retire_cnt", ws_retire_cnt, 32'd0);
`endif
                end
            end else begin
                chk("bubble_rf_we", 32'(rf_we), 32'd0);
                chk("bubble_flush", 32'(except_flush), 32'd0);
                chk("bubble_trace_we", 32'(debug_wb_rf_we), 32'd0);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_allowin"}, 32'(ws_allowin), 32'd1);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, "_flush"}, 32'(except_flush), 32'd0);
        chk({tag, "_flush_pc"}, flush_pc, 32'd0);
        chk({tag, "_ws_ex"}, 32'(ws_ex), 32'd0);
        chk({tag, "_ecode"}, 32'(ws_ecode), 32'd0);
        chk({tag, "_ertn"}, 32'(ws_ertn), 32'd0);
        chk({tag, "_pc"}, debug_wb_pc, 32'd0);
        chk({tag, "_wdata"}, rf_wdata, 32'd0);
        chk({tag, "_collect"}, ws_rf_collect[31:0], 32'd0);
        chk({tag, "_cnt"}, ws_retire_cnt, 32'd0);
    endtask

    exp_t none;

    initial begin
        none           = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetn         = 1'b0;
        ms_to_ws_valid = 1'b0;
        ms_rf_collect  = '0;
        ms_pc          = '0;
        ms_to_ws_bus   = '0;
        csr_eentry     = EENTRY;
        csr_era        = ERA;
        #3;
        chk_reset_outputs("rst0");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Four back-to-back retires, including an r0 write and a we=0 instruction
        send(1, {1'b1, 5'd3, 32'h1234_5678}, 32'h1C00_0000, 7'b0, 1,
             mk(32'h1C00_0000, 1, 3, 32'h1234_5678, 0, 0, 0, 0, 0));
        send(1, {1'b1, 5'd4, 32'hA5A5_A5A5}, 32'h1C00_0004, 7'b0, 1,
             mk(32'h1C00_0004, 1, 4, 32'hA5A5_A5A5, 0, 0, 0, 0, 0));
        send(1, {1'b1, 5'd0, 32'hDEAD_BEEF}, 32'h1C00_0008, 7'b0, 1,
             mk(32'h1C00_0008, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
        send(1, {1'b0, 5'd7, 32'h1111_1111}, 32'h1C00_000C, 7'b0, 1,
             mk(32'h1C00_000C, 0, 7, 32'h1111_1111, 0, 0, 0, 0, 0));

        // sys with we=1: write suppressed; the next offered instruction is dropped
        send(1, {1'b1, 5'd9, 32'h0000_0055}, 32'h1C00_0010, 7'b1000000, 1,
             mk(32'h1C00_0010, 0, 9, 32'h0000_0055, 1, 6'h0B, 0, 1, EENTRY));
        send(1, {1'b1, 5'd10, 32'h0000_0066}, 32'h1C00_0014, 7'b0, 0, none);
        send(0, '0, '0, 7'b0, 0, none);

        // int + ertn: exception wins, ertn suppressed
        send(1, {1'b0, 5'd0, 32'h0}, 32'h1C00_0018, 7'b0000011, 1,
             mk(32'h1C00_0018, 0, 0, 32'h0, 1, 6'h00, 0, 1, EENTRY));
        send(0, '0, '0, 7'b0, 0, none);

        // ertn: redirect to era, counted as retired, follower dropped
        send(1, {1'b0, 5'd0, 32'h0}, 32'h1C00_001C, 7'b0000001, 1,
             mk(32'h1C00_001C, 0, 0, 32'h0, 0, 6'h00, 1, 1, ERA));
        send(1, {1'b1, 5'd11, 32'h0000_0077}, 32'h1C00_0020, 7'b0, 0, none);

        // Exception code priority
        send(1, {1'b1, 5'd12, 32'h1}, 32'h1C00_0024, 7'b0110100, 1,
             mk(32'h1C00_0024, 0, 12, 32'h1, 1, 6'h08, 0, 1, EENTRY));
        send(0, '0, '0, 7'b0, 0, none);
        send(1, {1'b1, 5'd13, 32'h2}, 32'h1C00_0028, 7'b0110000, 1,
             mk(32'h1C00_0028, 0, 13, 32'h2, 1, 6'h0D, 0, 1, EENTRY));
        send(0, '0, '0, 7'b0, 0, none);
        send(1, {1'b1, 5'd14, 32'h3}, 32'h1C00_002C, 7'b1100000, 1,
             mk(32'h1C00_002C, 0, 14, 32'h3, 1, 6'h0B, 0, 1, EENTRY));
        send(0, '0, '0, 7'b0, 0, none);
        send(1, {1'b1, 5'd15, 32'h4}, 32'h1C00_0030, 7'b0101000, 1,
             mk(32'h1C00_0030, 0, 15, 32'h4, 1, 6'h0C, 0, 1, EENTRY));
        send(0, '0, '0, 7'b0, 0, none);
        send(1, {1'b1, 5'd16, 32'h5}, 32'h1C00_0034, 7'b0001000, 1,
             mk(32'h1C00_0034, 0, 16, 32'h5, 1, 6'h09, 0, 1, EENTRY));
        send(1, {1'b1, 5'd17, 32'h6}, 32'h1C00_0038, 7'b0, 0, none);

        // Normal retire after the flushes
        send(1, {1'b1, 5'd18, 32'hCAFE_0001}, 32'h1C00_003C, 7'b0, 1,
             mk(32'h1C00_003C, 1, 18, 32'hCAFE_0001, 0, 0, 0, 0, 0));

        // Async reset while an excepting instruction sits in WB
        send(1, {1'b1, 5'd19, 32'h0000_0099}, 32'h1C00_0040, 7'b1000000, 1,
             mk(32'h1C00_0040, 0, 19, 32'h0000_0099, 1, 6'h0B, 0, 1, EENTRY));
        ms_to_ws_valid = 1'b1;
        ms_rf_collect  = {1'b1, 5'd20, 32'h0000_00AA};
        ms_pc          = 32'h1C00_0044;
        ms_to_ws_bus   = 7'b0;
        @(negedge clk);
        #2;
        resetn  = 1'b0;
        exp_cnt = 32'd0;
        #1;
        chk_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        ms_to_ws_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        send(1, {1'b1, 5'd21, 32'hBEEF_0002}, 32'h1C00_0100, 7'b0, 1,
             mk(32'h1C00_0100, 1, 21, 32'hBEEF_0002, 0, 0, 0, 0, 0));
        send(0, '0, '0, 7'b0, 0, none);
        @(posedge clk);
        #1;

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
